// File: rtl/memory_writeback_stage_pkg.sv
// Shared definitions for the memory stage: access-size encodings and memory geometry defaults.
package mem_pkg;

    localparam int MEM_WORDS_DEF = 1024;
    localparam int IDX_W_DEF     = 10;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } mem_size_e;

    // Extend a 16-bit or 8-bit lane to 32 bits; 'half' selects the lane width.
    function automatic logic [31:0] lane_extend(input logic [15:0] lane, input logic half,
                                                input logic is_unsigned);
        logic [31:0] r;
        if (half) r = is_unsigned ? {16'h0000, lane} : {{16{lane[15]}}, lane};
        else      r = is_unsigned ? {24'h000000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        return r;
    endfunction

endpackage

// File: rtl/memory_writeback_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one interface.
// No valid/ready handshake: every cycle with Stall low carries exactly one instruction.
interface memory_writeback_stage_if;

    logic [31:0] MemoryALUResult;
    logic [31:0] MemoryReadData2;
    logic [4:0]  MemoryDstAddr;
    logic [31:0] MemoryJumpAddr;
    logic        MemoryZero;
    logic        MemoryBranch;
    logic        MemoryMemRead;
    logic        MemoryMemWrite;
    logic [1:0]  MemoryMemSize;
    logic        MemoryLoadUnsigned;
    logic        MemoryMemToReg;
    logic        MemoryRegWrite;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] AddrBranch;
    logic [4:0]  WBRegAddr;
    logic [31:0] WBWriteData;
    logic        WBRegWrite;
    logic        MisalignFault;

    modport master (
        output MemoryALUResult, MemoryReadData2, MemoryDstAddr, MemoryJumpAddr,
               MemoryZero, MemoryBranch, MemoryMemRead, MemoryMemWrite, MemoryMemSize,
               MemoryLoadUnsigned, MemoryMemToReg, MemoryRegWrite, Stall,
        input  PCSrc, AddrBranch, WBRegAddr, WBWriteData, WBRegWrite, MisalignFault
    );

    modport slave (
        input  MemoryALUResult, MemoryReadData2, MemoryDstAddr, MemoryJumpAddr,
               MemoryZero, MemoryBranch, MemoryMemRead, MemoryMemWrite, MemoryMemSize,
               MemoryLoadUnsigned, MemoryMemToReg, MemoryRegWrite, Stall,
        output PCSrc, AddrBranch, WBRegAddr, WBWriteData, WBRegWrite, MisalignFault
    );

endinterface

// File: rtl/memory_writeback_stage_data_memory.sv
// Word-organised data memory: byte-enabled synchronous write, combinational read.
module data_memory
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    // Read sees the pre-edge contents, so a same-cycle load returns the old word.
    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/memory_writeback_stage.sv
// Memory stage: branch resolve, sub-word loads/stores, misalignment tracking and the MEM/WB register.
module memory_writeback_stage
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic                      Clk,
    input  logic                      Rst,
    memory_writeback_stage_if.slave   bus
);

    logic [31:0]      addr;
    logic [IDX_W-1:0] word_idx;
    logic             is_half;
    logic             is_byte;
    logic             is_word;
    logic             misalign;
    logic             store_en;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rword;
    logic [31:0]      load_data;
    logic             unused_addr_bits;

    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_we_q,   wb_we_d;
    logic        fault_q,   fault_d;

    assign addr     = bus.MemoryALUResult;
    assign word_idx = addr[IDX_W+1:2];
    // Upper address bits are deliberately dropped so accesses wrap around the array.
    assign unused_addr_bits = ^addr[31:IDX_W+2];

    assign is_half = (bus.MemoryMemSize == SZ_HALF);
    assign is_byte = (bus.MemoryMemSize == SZ_BYTE);
    assign is_word = !is_half && !is_byte;

    assign misalign = (bus.MemoryMemRead || bus.MemoryMemWrite) &&
                      ((is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]));

    // Rst gating keeps a store from landing on an edge where reset is held.
    assign store_en = bus.MemoryMemWrite && !misalign && !bus.Stall && Rst;

    always_comb begin
        be    = 4'b1111;
        wdata = bus.MemoryReadData2;
        if (is_half) begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{bus.MemoryReadData2[15:0]}};
        end else if (is_byte) begin
            be    = 4'b0001 << addr[1:0];
            wdata = {4{bus.MemoryReadData2[7:0]}};
        end
    end

    data_memory #(
        .MEM_WORDS(MEM_WORDS),
        .IDX_W    (IDX_W)
    ) u_data_memory (
        .clk_i  (Clk),
        .we_i   (store_en),
        .be_i   (be),
        .idx_i  (word_idx),
        .wdata_i(wdata),
        .rdata_o(rword)
    );

    always_comb begin
        load_data = rword;
        if (is_half) begin
            load_data = lane_extend(addr[1] ? rword[31:16] : rword[15:0], 1'b1,
                                    bus.MemoryLoadUnsigned);
        end else if (is_byte) begin
            load_data = lane_extend({8'h00, rword[8*addr[1:0] +: 8]}, 1'b0,
                                    bus.MemoryLoadUnsigned);
        end
        if (misalign) load_data = 32'h0;
    end

    always_comb begin
        wb_addr_d = bus.MemoryDstAddr;
        wb_data_d = bus.MemoryMemToReg ? load_data : addr;
        wb_we_d   = bus.MemoryRegWrite && !(misalign && bus.MemoryMemToReg) &&
                    (bus.MemoryDstAddr != 5'd0);
        fault_d   = fault_q || misalign;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wb_addr_q <= 5'd0;
            wb_data_q <= 32'h0;
            wb_we_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else if (!bus.Stall) begin
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.PCSrc         = bus.MemoryBranch && bus.MemoryZero && !bus.Stall;
    assign bus.AddrBranch    = bus.MemoryJumpAddr;
    assign bus.WBRegAddr     = wb_addr_q;
    assign bus.WBWriteData   = wb_data_q;
    assign bus.WBRegWrite    = wb_we_q;
    assign bus.MisalignFault = fault_q;

endmodule
